// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op/class codes and divider encodings for the MIPS32 execute stage.
package ex_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [AluOpBus-1:0] EXE_MOVZ_OP  = 8'b00001010;
  localparam logic [AluOpBus-1:0] EXE_MOVN_OP  = 8'b00001011;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [AluOpBus-1:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [AluOpBus-1:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [AluOpBus-1:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [AluOpBus-1:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [AluOpBus-1:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [AluOpBus-1:0] EXE_CLZ_OP   = 8'b10110000;
  localparam logic [AluOpBus-1:0] EXE_CLO_OP   = 8'b10110001;
  localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [AluOpBus-1:0] EXE_MUL_OP   = 8'b10101001;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b00011011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [AluSelBus-1:0] EXE_RES_MUL   = 3'b101;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_RUN    = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit && !v[i]) n = n + 6'd1;
      else hit = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// 32-step restoring divider for DIV/DIVU; signs are stripped on entry and restored on completion.
// state      | meaning
// DIV_IDLE   | waiting for start
// DIV_BYZERO | divisor was zero, result forced to 0
// DIV_RUN    | one shift-subtract step per cycle
// DIV_DONE   | result_o valid for one cycle
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        neg_q, rneg_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [32:0] partial_d, diff_d;
  logic [31:0] quo_d, rem_d, quo_s, rem_s, abs1, abs2;

  always_comb begin
    partial_d = {rem_q, quo_q[31]};
    diff_d    = partial_d - {1'b0, dvs_q};
    if (!diff_d[32]) begin
      rem_d = diff_d[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = partial_d[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
    quo_s = neg_q  ? -quo_d : quo_d;
    rem_s = rneg_q ? -rem_d : rem_d;
    abs1  = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    abs2  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      ready_q  <= DivResultNotReady;
      result_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_RUN;
              cnt_q   <= '0;
              quo_q   <= abs1;
              rem_q   <= '0;
              dvs_q   <= abs2;
              neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              rneg_q  <= signed_div_i && opdata1_i[31];
            end
          end
        end
        DIV_BYZERO: begin
          state_q  <= DIV_DONE;
          result_q <= '0;
          ready_q  <= DivResultReady;
        end
        DIV_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q  <= DIV_DONE;
            result_q <= {rem_s, quo_s};
            ready_q  <= DivResultReady;
          end
        end
        default: begin
          state_q  <= DIV_IDLE;
          ready_q  <= DivResultNotReady;
          result_q <= '0;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU/HI-LO/multiply results plus optional sequential divider.
// Divider and DIV/DIVU support are built only when EX_DIV_EN is defined.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] w_addr_i,
  input  logic                  we_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  mem_whilo_i,
  input  logic [RegBus-1:0]     mem_hi_i,
  input  logic [RegBus-1:0]     mem_lo_i,
  input  logic                  wb_whilo_i,
  input  logic [RegBus-1:0]     wb_hi_i,
  input  logic [RegBus-1:0]     wb_lo_i,
  input  logic                  annul_i,
  output logic [RegAddrBus-1:0] w_addr_o,
  output logic                  we_o,
  output logic [RegBus-1:0]     w_data_o,
  output logic                  whilo_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  stall_req_o
);

  logic [31:0] hi_fwd, lo_fwd, sum, diff, logic_res, shift_res, w_data;
  logic [63:0] prod_s, prod_u;
  logic        ov_block, is_div, div_stall, div_done;
  logic [31:0] div_hi, div_lo;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign sum    = reg1_i + reg2_i;
  assign diff   = reg1_i - reg2_i;
  assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

  // Signed overflow on ADD/ADDI/SUB cancels the GPR write.
  assign ov_block = (((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP)) &&
                     (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31])) ||
                    ((aluop_i == EXE_SUB_OP) &&
                     (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]));

`ifdef EX_DIV_EN
  logic [63:0] div_result;
  logic        div_ready;

  ex_div u_div (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (aluop_i == EXE_DIV_OP),
    .opdata1_i    (reg1_i),
    .opdata2_i    (reg2_i),
    .start_i      ((is_div && (div_ready == DivResultNotReady)) ? DivStart : DivStop),
    .annul_i      (annul_i),
    .result_o     (div_result),
    .ready_o      (div_ready)
  );

  assign div_stall = is_div && (div_ready == DivResultNotReady);
  assign div_done  = is_div && (div_ready == DivResultReady) && !annul_i;
  assign div_hi    = div_result[63:32];
  assign div_lo    = div_result[31:0];
`else
  logic div_unused;
  assign div_unused = clk ^ annul_i;
  assign div_stall  = 1'b0;
  assign div_done   = 1'b0;
  assign div_hi     = '0;
  assign div_lo     = '0;
`endif

  always_comb begin
    hi_fwd = hi_i;
    lo_fwd = lo_i;
    if (mem_whilo_i) begin
      hi_fwd = mem_hi_i;
      lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_fwd = wb_hi_i;
      lo_fwd = wb_lo_i;
    end
  end

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default: ;
    endcase
  end

  always_comb begin
    w_data = '0;
    case (alusel_i)
      EXE_RES_LOGIC: w_data = logic_res;
      EXE_RES_SHIFT: w_data = shift_res;
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP:              w_data = hi_fwd;
          EXE_MFLO_OP:              w_data = lo_fwd;
          EXE_MOVN_OP, EXE_MOVZ_OP: w_data = reg1_i;
          default: ;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_SLT_OP:  w_data = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
          EXE_SLTU_OP: w_data = {31'b0, reg1_i < reg2_i};
          EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: w_data = sum;
          EXE_SUB_OP, EXE_SUBU_OP: w_data = diff;
          EXE_CLZ_OP:  w_data = {26'b0, clz32(reg1_i)};
          EXE_CLO_OP:  w_data = {26'b0, clz32(~reg1_i)};
          default: ;
        endcase
      end
      EXE_RES_MUL: w_data = prod_s[31:0];
      default: ;
    endcase
  end

  always_comb begin
    w_addr_o    = '0;
    we_o        = 1'b0;
    w_data_o    = '0;
    whilo_o     = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    stall_req_o = 1'b0;
    if (!rst) begin
      w_addr_o    = w_addr_i;
      w_data_o    = w_data;
      we_o        = we_i && !ov_block && !is_div;
      stall_req_o = div_stall;
      case (aluop_i)
        EXE_MULT_OP:  begin whilo_o = 1'b1; hi_o = prod_s[63:32]; lo_o = prod_s[31:0]; end
        EXE_MULTU_OP: begin whilo_o = 1'b1; hi_o = prod_u[63:32]; lo_o = prod_u[31:0]; end
        EXE_MTHI_OP:  begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = lo_fwd; end
        EXE_MTLO_OP:  begin whilo_o = 1'b1; hi_o = hi_fwd; lo_o = reg1_i; end
        EXE_DIV_OP, EXE_DIVU_OP: begin
          whilo_o = div_done;
          hi_o    = div_done ? div_hi : '0;
          lo_o    = div_done ? div_lo : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS32 pipeline, directly downstream of the ID decoder. Consumes the decoded `aluop`/`alusel`/operands/destination, computes logic, shift, move, arithmetic and multiply results, and resolves HI/LO reads with forwarding from MEM and WB. Hosts a 32-iteration sequential divider for DIV/DIVU that stalls the pipeline until the quotient and remainder are ready. Its `we_o`/`w_addr_o`/`w_data_o` also drive the EX→ID forwarding path.

## Interface
- No parameters. Widths come from the shared defines: RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-high
- aluop_i / alusel_i  in  8 / 3  operation subtype and class from ID
- reg1_i, reg2_i  in  32 each  operands from ID (reg1 is rs or sa/imm; reg2 is rt or imm)
- w_addr_i, we_i  in  5 / 1  destination register and write enable from ID
- hi_i, lo_i  in  32 each  committed HI/LO register values
- mem_whilo_i, mem_hi_i, mem_lo_i  in  1/32/32  HI/LO write in MEM
- wb_whilo_i, wb_hi_i, wb_lo_i  in  1/32/32  HI/LO write in WB
- annul_i  in  1  abort an in-flight division
- w_addr_o, we_o, w_data_o  out  5/1/32  GPR write request
- whilo_o, hi_o, lo_o  out  1/32/32  HI/LO write request
- stall_req_o  out  1  hold IF/ID/EX while the divider is busy

## Operation
- Combinational result path. While rst is high, every output is 0.
- HI/LO source priority: MEM forward, then WB forward, then hi_i/lo_i.
- Logic ops (OR/AND/XOR/NOR): operate on reg1 and reg2. Shift ops: reg2 shifted by reg1[4:0]; SRA sign-fills.
- MFHI/MFLO: w_data_o is the forwarded HI or LO.
- MTHI: whilo_o=1, hi_o=reg1, lo_o=forwarded LO. MTLO is the mirror case.
- MOVN/MOVZ: w_data_o=reg1. we_o passes through from ID.
- ADD/ADDI/SUB: on signed overflow, we_o=0. ADDU/ADDIU/SUBU wrap modulo 2^32.
- SLT compares signed; SLTU compares unsigned; the result is 0 or 1.
- CLZ/CLO: count of leading zeros or ones. The result is 32 for all-zero or all-one input respectively.
- MULT/MULTU: 64-bit product, whilo_o=1, hi_o=[63:32], lo_o=[31:0].
- MUL: w_data_o is the low 32 bits of the signed product; whilo_o=0.
- Divider FSM states: IDLE, BYZERO, RUN, DONE. All state is reset to IDLE with counter 0.
  - IDLE → BYZERO when the op is DIV/DIVU and reg2=0.
  - IDLE → RUN for a nonzero DIV/DIVU divisor. On entry it latches |reg1| and |reg2| (raw values for DIVU) and clears the counter.
  - RUN performs one restoring shift-subtract step per cycle. It moves to DONE when the counter reaches 32.
  - BYZERO → DONE with quotient=0 and remainder=0.
  - DONE: apply signs. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - DONE outputs whilo_o=1, hi_o=remainder, lo_o=quotient, then returns to IDLE on the next edge.
  - annul_i or rst in any state forces IDLE on the next edge and suppresses whilo_o.
- stall_req_o=1 whenever the op is DIV/DIVU and the FSM is not in DONE.

## Timing
- All non-divide ops: 0-cycle combinational result, valid in the same cycle the op is presented.
- DIV with nonzero divisor:
  - op presented in cycle 0, while the FSM is in IDLE;
  - RUN occupies cycles 1–32;
  - DONE in cycle 33.
  - stall_req_o is high for cycles 0–32 (33 cycles) and the result is valid in cycle 33.
- Divide by zero: stall_req_o high in cycles 0–1, DONE in cycle 2.
- ID holds aluop/operands stable while stalled. The latched divider operands are not re-sampled during RUN.
- Back-to-back DIVs: the second starts from IDLE one cycle after the first's DONE.

## Configuration
- `EX_DIV_EN` defined: divider FSM and DIV/DIVU support are built.
- `EX_DIV_EN` undefined: DIV/DIVU behave as NOP (whilo_o=0, we_o=0) and stall_req_o is tied to 0.

## Structure
- Shared defines/package gains:
  - new codes `EXE_DIV_OP` and `EXE_DIVU_OP`;
  - divider state encodings;
  - DivResultNotReady/DivResultReady and DivStart/DivStop constants;
  - existing aluop/alusel codes reused unchanged.
- Sub-module `ex_div`:
  - inputs: signed_div, opdata1, opdata2, start, annul;
  - outputs: result[63:0], ready;
  - contains the FSM.
- `ex_stage` derives start from the decoded op and ready.

## Test plan
- ORI-style: aluop OR, reg1=0x1100, reg2=0x0020 → w_data_o=0x1120, we_o=1, stall_req_o=0.
- ADD 0x7FFFFFFF+1 → we_o=0. ADDU of the same operands → w_data_o=0x80000000, we_o=1.
- MTHI reg1=0x5, then MFHI with mem_whilo_i=1 and mem_hi_i=0xAA → w_data_o=0xAA (MEM forward beats hi_i).
- MULT reg1=0xFFFFFFFF (−1), reg2=2 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, whilo_o=1.
- DIV −7/2:
  - stall_req_o high for 33 cycles;
  - cycle 33: lo_o=0xFFFFFFFD (−3), hi_o=0xFFFFFFFF (−1), whilo_o=1.
- DIVU 9/0 → DONE in cycle 2 with hi_o=lo_o=0. Second run: a DIV with annul_i pulsed in cycle 10 → IDLE at cycle 11, whilo_o never asserted.
